exc_ctrl: RTL and testbench

- Exception/ERET sequencer directly upstream of the CP0 register file.
- Takes per-instruction exception flags and ERET from the MEM stage, plus the pending-interrupt vector from CP0.
- Produces the single-cycle `reg_error` write into CP0, flushes the pipeline, and hands a redirect PC to fetch over a valid/ready handshake.
- Returns from exceptions using the EPC that CP0 supplies.

---
 rtl/exc_ctrl_pkg.sv | 47 ++++
 rtl/exc_ctrl_prio.sv | 52 +++++
 rtl/exc_ctrl.sv | 161 ++++++++++++++++
 tb/tb_exc_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_ctrl_pkg.sv
// Shared types for the exception/ERET sequencer: exception codes, MEM-stage flag layout, CP0 error-write record.
// Pure declarations; no logic.
package exc_ctrl_pkg;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC00380;

    typedef enum logic [4:0] {
        INT  = 5'd0,
        ADEL = 5'd4,
        ADES = 5'd5,
        SYS  = 5'd8,
        BP   = 5'd9,
        RI   = 5'd10,
        OV   = 5'd12
    } exc_code_t;

    // Bit order matches mem_flags[6:0] = {adel_if, ri, ov, sys, bp, adel_d, ades}
    typedef struct packed {
        logic adel_if;
        logic ri;
        logic ov;
        logic sys;
        logic bp;
        logic adel_d;
        logic ades;
    } exc_flags_t;

    typedef struct packed {
        logic        we;
        logic        bd;
        logic        exl;
        logic [4:0]  exc;
        logic [31:0] epc;
        logic [31:0] bva;
    } reg_error;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FLUSH    = 2'd1,
        S_REDIRECT = 2'd2
    } state_t;

    function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
        return bd ? pc - 32'd4 : pc;
    endfunction

endpackage

// File: rtl/exc_ctrl_prio.sv
// Exception priority encoder: picks the highest-priority source and its code/EPC/BadVAddr.
// Latency: combinational. Backpressure: none.
// Caller gates take with mem_valid and idle state.
module exc_ctrl_prio
    import exc_ctrl_pkg::*;
(
    input  logic [7:0]  intr_q,
    input  logic [6:0]  mem_flags,
    input  logic [31:0] mem_pc,
    input  logic        mem_bd,
    input  logic [31:0] mem_badaddr,
    output logic        take,
    output logic [4:0]  exc,
    output logic [31:0] epc,
    output logic [31:0] bva
);

    exc_flags_t f;
    exc_code_t  code;

    always_comb begin
        f    = exc_flags_t'(mem_flags);
        take = 1'b1;
        code = INT;
        bva  = 32'd0;
        if (intr_q != 8'd0) begin
            code = INT;
        end else if (f.adel_if) begin
            code = ADEL;
            bva  = mem_pc;
        end else if (f.ri) begin
            code = RI;
        end else if (f.ov) begin
            code = OV;
        end else if (f.sys) begin
            code = SYS;
        end else if (f.bp) begin
            code = BP;
        end else if (f.adel_d) begin
            code = ADEL;
            bva  = mem_badaddr;
        end else if (f.ades) begin
            code = ADES;
            bva  = mem_badaddr;
        end else begin
            take = 1'b0;
        end
        exc = code;
        epc = epc_of(mem_pc, mem_bd);
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/ERET sequencer: one-cycle CP0 error write, pipeline flush, then redirect PC to fetch.
// Latency: cp0w/flush one cycle after acceptance; redirect offered after FLUSH_CYCLES flush cycles.
// Backpressure: redirect held until redirect_ready; busy stalls the pipe. Optional EXC_CTRL_COUNT_EN adds exc_count.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic        mem_bd,
    input  logic [6:0]  mem_flags,
    input  logic [31:0] mem_badaddr,
    input  logic        mem_eret,
    input  logic [7:0]  intr_vect,
    input  logic [31:0] er_epc,
    output reg_error    cp0w,
    output logic        flush,
    output logic        busy,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready
`ifdef EXC_CTRL_COUNT_EN
    ,
    output logic [31:0] exc_count
`endif
);

    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  intr_q;
    reg_error    cp0w_d;
    logic        flush_d;
    logic        rv_d;
    logic [31:0] rpc_d;
    logic        sh_bd_q, sh_bd_d;
    logic [4:0]  sh_exc_q, sh_exc_d;
    logic [31:0] sh_bva_q, sh_bva_d;

    logic        take;
    logic [4:0]  p_exc;
    logic [31:0] p_epc;
    logic [31:0] p_bva;

    exc_ctrl_prio u_prio (
        .intr_q      (intr_q),
        .mem_flags   (mem_flags),
        .mem_pc      (mem_pc),
        .mem_bd      (mem_bd),
        .mem_badaddr (mem_badaddr),
        .take        (take),
        .exc         (p_exc),
        .epc         (p_epc),
        .bva         (p_bva)
    );

    assign busy = (state_q != S_IDLE);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cp0w_d   = '0;
        flush_d  = flush;
        rv_d     = redirect_valid;
        rpc_d    = redirect_pc;
        sh_bd_d  = sh_bd_q;
        sh_exc_d = sh_exc_q;
        sh_bva_d = sh_bva_q;
        case (state_q)
            S_IDLE: begin
                if (mem_valid && take) begin
                    cp0w_d.we  = 1'b1;
                    cp0w_d.bd  = mem_bd;
                    cp0w_d.exl = 1'b1;
                    cp0w_d.exc = p_exc;
                    cp0w_d.epc = p_epc;
                    cp0w_d.bva = p_bva;
                    sh_bd_d    = mem_bd;
                    sh_exc_d   = p_exc;
                    sh_bva_d   = p_bva;
                    rpc_d      = EXC_VECTOR;
                    flush_d    = 1'b1;
                    cnt_d      = CNT_INIT;
                    state_d    = S_FLUSH;
                end else if (mem_valid && mem_eret) begin
                    // ERET replays the last exception's bd/exc/bva with EXL cleared
                    cp0w_d.we  = 1'b1;
                    cp0w_d.bd  = sh_bd_q;
                    cp0w_d.exl = 1'b0;
                    cp0w_d.exc = sh_exc_q;
                    cp0w_d.epc = er_epc;
                    cp0w_d.bva = sh_bva_q;
                    rpc_d      = er_epc;
                    flush_d    = 1'b1;
                    cnt_d      = CNT_INIT;
                    state_d    = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    flush_d = 1'b0;
                    rv_d    = 1'b1;
                    state_d = S_REDIRECT;
                end
            end
            S_REDIRECT: begin
                if (redirect_ready) begin
                    rv_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= 4'd0;
            intr_q         <= 8'd0;
            cp0w           <= '0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
            sh_bd_q        <= 1'b0;
            sh_exc_q       <= 5'd0;
            sh_bva_q       <= 32'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            intr_q         <= intr_vect;
            cp0w           <= cp0w_d;
            flush          <= flush_d;
            redirect_valid <= rv_d;
            redirect_pc    <= rpc_d;
            sh_bd_q        <= sh_bd_d;
            sh_exc_q       <= sh_exc_d;
            sh_bva_q       <= sh_bva_d;
        end
    end

`ifdef EXC_CTRL_COUNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            exc_count <= 32'd0;
        end else if (cp0w.we && cp0w.exl && (exc_count != 32'hFFFF_FFFF)) begin
            exc_count <= exc_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: directed steps then randomized traffic against a cycle-count reference model.
module tb_exc_ctrl;
    import exc_ctrl_pkg::*;

    localparam int          FC  = 2;
    localparam logic [31:0] VEC = 32'hBFC00380;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic        mem_bd;
    logic [6:0]  mem_flags;
    logic [31:0] mem_badaddr;
    logic        mem_eret;
    logic [7:0]  intr_vect;
    logic [31:0] er_epc;
    reg_error    cp0w;
    logic        flush;
    logic        busy;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
`ifdef EXC_CTRL_COUNT_EN
    logic [31:0] exc_count;
`endif

    exc_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_valid      (mem_valid),
        .mem_pc         (mem_pc),
        .mem_bd         (mem_bd),
        .mem_flags      (mem_flags),
        .mem_badaddr    (mem_badaddr),
        .mem_eret       (mem_eret),
        .intr_vect      (intr_vect),
        .er_epc         (er_epc),
        .cp0w           (cp0w),
        .flush          (flush),
        .busy           (busy),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready)
`ifdef EXC_CTRL_COUNT_EN
        ,
        .exc_count      (exc_count)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: "cycles since acceptance" instead of an explicit state machine
    reg_error    m_cp0w;
    bit          m_busy;
    int          m_since;
    logic [31:0] m_rpc;
    logic [7:0]  m_intr;
    logic        m_sh_bd;
    logic [4:0]  m_sh_exc;
    logic [31:0] m_sh_bva;
    logic [31:0] m_count;

    function automatic void prio(input logic [7:0] iq, input logic [6:0] fl,
                                 input logic [31:0] pc, input logic [31:0] ba,
                                 output bit tk, output logic [4:0] code, output logic [31:0] bva);
        logic [4:0] codes [0:6];
        codes = '{5'd4, 5'd10, 5'd12, 5'd8, 5'd9, 5'd4, 5'd5};
        tk = 1'b0; code = 5'd0; bva = 32'd0;
        if (iq != 8'd0) begin
            tk = 1'b1;
        end else begin
            for (int k = 0; k < 7; k++) begin
                if (!tk && fl[6-k]) begin
                    tk   = 1'b1;
                    code = codes[k];
                    bva  = (k == 0) ? pc : ((k >= 5) ? ba : 32'd0);
                end
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        reg_error    nxt;
        bit          tk;
        logic [4:0]  code;
        logic [31:0] bva;
        nxt = '0;
        if (!rst) begin
            m_busy = 1'b0; m_since = 0; m_rpc = 32'd0; m_intr = 8'd0;
            m_sh_bd = 1'b0; m_sh_exc = 5'd0; m_sh_bva = 32'd0; m_count = 32'd0;
        end else begin
            if (m_cp0w.we && m_cp0w.exl && m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
            if (!m_busy) begin
                prio(m_intr, mem_flags, mem_pc, mem_badaddr, tk, code, bva);
                if (mem_valid && tk) begin
                    nxt = '{we: 1'b1, bd: mem_bd, exl: 1'b1, exc: code,
                            epc: (mem_bd ? mem_pc - 32'd4 : mem_pc), bva: bva};
                    m_sh_bd = mem_bd; m_sh_exc = code; m_sh_bva = bva;
                    m_rpc = VEC; m_busy = 1'b1; m_since = 0;
                end else if (mem_valid && mem_eret) begin
                    nxt = '{we: 1'b1, bd: m_sh_bd, exl: 1'b0, exc: m_sh_exc,
                            epc: er_epc, bva: m_sh_bva};
                    m_rpc = er_epc; m_busy = 1'b1; m_since = 0;
                end
            end else if (m_since >= FC) begin
                if (redirect_ready) m_busy = 1'b0;
            end else begin
                m_since++;
            end
            m_intr = intr_vect;
        end
        m_cp0w = nxt;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("cp0w", 72'(cp0w), 72'(m_cp0w));
        chk("flush", 72'(flush), 72'(m_busy && m_since < FC));
        chk("busy", 72'(busy), 72'(m_busy));
        chk("redirect_valid", 72'(redirect_valid), 72'(m_busy && m_since >= FC));
        chk("redirect_pc", 72'(redirect_pc), 72'(m_rpc));
`ifdef EXC_CTRL_COUNT_EN
        chk("exc_count", 72'(exc_count), 72'(m_count));
`endif
    endtask

    task automatic idle_in();
        mem_valid = 1'b0; mem_flags = 7'd0; mem_eret = 1'b0; intr_vect = 8'd0;
    endtask

    reg_error e;

    initial begin
        m_cp0w = '0; m_busy = 0; m_since = 0; m_rpc = 0; m_intr = 0;
        m_sh_bd = 0; m_sh_exc = 0; m_sh_bva = 0; m_count = 0;
        rst = 1'b0; idle_in();
        mem_pc = 32'd0; mem_bd = 1'b0; mem_badaddr = 32'd0; er_epc = 32'd0; redirect_ready = 1'b0;
        #2;
        tick(); tick();
        chk("reset_cp0w", 72'(cp0w), 72'd0);
        chk("reset_rpc", 72'(redirect_pc), 72'd0);
        rst = 1'b1; redirect_ready = 1'b1;
        tick();

        // Overflow, no delay slot
        mem_valid = 1'b1; mem_flags = 7'b0010000; mem_pc = 32'h80000010; mem_bd = 1'b0;
        tick();
        e = '{we: 1'b1, bd: 1'b0, exl: 1'b1, exc: 5'd12, epc: 32'h80000010, bva: 32'd0};
        chk("ov_cp0w", 72'(cp0w), 72'(e));
        idle_in();
        tick();
        chk("ov_flush2", 72'(flush), 72'd1);
        tick();
        chk("ov_rv", 72'(redirect_valid), 72'd1);
        chk("ov_rpc", 72'(redirect_pc), 72'(VEC));
        tick();
        chk("ov_idle", 72'(busy), 72'd0);

        // Data address error in a delay slot
        mem_valid = 1'b1; mem_flags = 7'b0000010; mem_badaddr = 32'h00000003;
        mem_pc = 32'h80000104; mem_bd = 1'b1;
        tick();
        e = '{we: 1'b1, bd: 1'b1, exl: 1'b1, exc: 5'd4, epc: 32'h80000100, bva: 32'h00000003};
        chk("adel_cp0w", 72'(cp0w), 72'(e));
        idle_in();
        repeat (3) tick();

        // Interrupt sampled while bubble, taken over RI on next valid instruction
        intr_vect = 8'h04; mem_bd = 1'b0; mem_pc = 32'h80000400;
        tick();
        intr_vect = 8'h00; mem_valid = 1'b1; mem_flags = 7'b0100000;
        tick();
        e = '{we: 1'b1, bd: 1'b0, exl: 1'b1, exc: 5'd0, epc: 32'h80000400, bva: 32'd0};
        chk("int_cp0w", 72'(cp0w), 72'(e));
        repeat (3) tick();
        idle_in();
        tick();

        // Syscall then ERET
        mem_valid = 1'b1; mem_flags = 7'b0001000; mem_pc = 32'h80000300;
        tick();
        idle_in();
        repeat (3) tick();
        mem_valid = 1'b1; mem_eret = 1'b1; er_epc = 32'h80000200;
        tick();
        e = '{we: 1'b1, bd: 1'b0, exl: 1'b0, exc: 5'd8, epc: 32'h80000200, bva: 32'd0};
        chk("eret_cp0w", 72'(cp0w), 72'(e));
        idle_in();
        tick(); tick();
        chk("eret_rpc", 72'(redirect_pc), 72'h80000200);
        tick();

        // Redirect stall with ignored flags, then reset mid-REDIRECT
        redirect_ready = 1'b0;
        mem_valid = 1'b1; mem_flags = 7'b0010000; mem_pc = 32'h80000500;
        repeat (3) tick();
        repeat (5) tick();
        chk("hold_rv", 72'(redirect_valid), 72'd1);
        chk("hold_rpc", 72'(redirect_pc), 72'(VEC));
        rst = 1'b0;
        tick();
        chk("midrst_cp0w", 72'(cp0w), 72'd0);
        chk("midrst_rv", 72'(redirect_valid), 72'd0);
        rst = 1'b1; idle_in();
        tick();

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            rst            = ($urandom_range(0, 79) != 0);
            mem_valid      = ($urandom_range(0, 3) != 0);
            mem_flags      = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'd0;
            mem_eret       = ($urandom_range(0, 4) == 0);
            intr_vect      = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'd0;
            mem_pc         = $urandom;
            mem_bd         = 1'($urandom_range(0, 1));
            mem_badaddr    = $urandom;
            er_epc         = $urandom;
            redirect_ready = 1'($urandom_range(0, 1));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
